tw_master_arbiter: RTL
======================

Name: tw_master_arbiter

Overview:
- Synthesizable three-wire bus master that shares one three-wire bus between TWM_NUM_REQ on-chip requesters.
- Arbitrates requests, serialises each granted transaction onto the bus and returns read data.
- Bus frame: mode bit (1 = write), then address MSB-first, then data MSB-first. Chipselect is active-low. Slave samples on the rising edge of tw_bus_clock.
- Sits between register-access clients and the external three-wire slave.

Parameters:
- TWM_ADDRESS_BITS, 10, address field width.
- TWM_DATA_BITS, 32, data field width.
- TWM_NUM_REQ, 2, number of requesters (>=1).
- TWM_CLK_DIV, 4, system clock cycles per bus half-period (>=1).
- TWM_CS_GAP, 2, minimum chipselect-high time between frames, in half-periods (>=1).

Ports:
- clock  in  1  system clock; all logic on its rising edge. Single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  TWM_NUM_REQ  per-requester request; held high with payload stable until grant.
- req_wr  in  TWM_NUM_REQ  per-requester mode: 1 = write, 0 = read.
- req_addr  in  TWM_NUM_REQ*TWM_ADDRESS_BITS  packed addresses; requester i in slice i.
- req_wdata  in  TWM_NUM_REQ*TWM_DATA_BITS  packed write data.
- grant  out  TWM_NUM_REQ  one-hot, one-cycle pulse; payload captured this cycle.
- done  out  1  one-cycle pulse at end of frame.
- done_id  out  clog2(TWM_NUM_REQ) (min 1)  index of the requester whose frame finished; valid with done.
- rd_data  out  TWM_DATA_BITS  read result; valid with done for read frames, otherwise holds its last value.
- busy  out  1  high from grant until the end of the gap.
- tw_bus_clock  out  1  bus clock; idles low.
- tw_bus_chipselect  out  1  active-low chipselect; idles high.
- tw_bus_data  inout  1  bidirectional data; hi-Z when the master is not driving.

Behaviour:
- Reset values (asynchronous, immediate): grant=0, done=0, done_id=0, rd_data=0, busy=0, tw_bus_clock=0, tw_bus_chipselect=1, data output enable=0, state=IDLE, round-robin pointer=0.
- Reset mid-frame: bus returns to idle immediately; the in-flight transaction is discarded with no done pulse.
- States: IDLE, LOW, HIGH, STOP, GAP.
- Internal counters: half-period counter 0..TWM_CLK_DIV-1; bit counter over N = 1 + TWM_ADDRESS_BITS + TWM_DATA_BITS bits.
- IDLE: when any req is high, the winner is chosen combinationally. On the next clock edge:
  - grant[winner]=1;
  - mode, address and write data are latched into a shift register;
  - tw_bus_chipselect=0;
  - data is driven with the mode bit;
  - busy=1;
  - go to LOW.
- LOW (tw_bus_clock=0, TWM_CLK_DIV cycles): go to HIGH and raise tw_bus_clock.
- HIGH (tw_bus_clock=1, TWM_CLK_DIV cycles): drop tw_bus_clock, then:
  - if bit count < N-1: increment, go to LOW; the master shifts out the next bit in the same cycle that the clock falls;
  - else go to STOP.
- Write frames: master drives all N bits.
- Read frames:
  - Master drives the mode bit and address bits only.
  - Output enable is released on the falling edge that ends the last address bit.
  - The slave drives each data bit from the rising edge of that bit.
  - The master samples tw_bus_data on every falling edge in the data phase, shifting MSB-first into rd_data. The last bit is sampled on HIGH->STOP.
  - No contention: the master is hi-Z before the first data rising edge.
- STOP: clock low, chipselect low, TWM_CLK_DIV cycles. Then:
  - chipselect=1, output enable=0;
  - pulse done, with done_id set and rd_data updated for reads;
  - go to GAP.
- GAP: TWM_CS_GAP*TWM_CLK_DIV cycles. Then busy=0, go to IDLE. A request pending at that point is granted on the following edge.
- Frame timing: grant to chipselect rising = N*2*TWM_CLK_DIV + TWM_CLK_DIV cycles. Defaults: 43*8+4 = 348.
- Arbitration: round-robin. The search starts at pointer p and wraps modulo TWM_NUM_REQ. After granting i, p = (i+1) mod TWM_NUM_REQ.
- Requests are ignored outside IDLE. They are not queued, only held by the requester.
- A requester dropping req before grant is legal; it is simply never granted.
- Simultaneous requests: only one grant per frame.
- TWM_NUM_REQ=1: grant follows req whenever IDLE.

Optional Feature:
- Macro TWM_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the pointer is unused.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with req=0 -> chipselect=1, tw_bus_clock=0, data hi-Z, busy=0. Assert reset_n=0 mid-frame -> same values within the same cycle; no done.
- Requester 0 write addr=0x155, wdata=0xDEADBEEF -> slave model captures mode=1, address 0x155, data 0xDEADBEEF after 43 rising edges; done with done_id=0, 348 cycles after grant.
- Requester 1 read addr=0x2AA, slave returns 0x12345678 -> master releases data before the first data rising edge (no X on bus); rd_data=0x12345678 and done_id=1 on done.
- req=2'b11 held continuously -> grants alternate 0,1,0,1. With TWM_FIXED_PRIORITY_EN defined -> always 0 until req[0] drops.
- Back-to-back frames -> chipselect high for exactly TWM_CS_GAP*TWM_CLK_DIV = 8 cycles between frames; tw_bus_clock low throughout the gap.
- TWM_CLK_DIV=1, TWM_DATA_BITS=8 -> frame length (1+10+8)*2+1 = 39 cycles; read/write data integrity unchanged.

Source files
------------

// File: rtl/tw_master_arbiter.sv
// rtl/tw_master_arbiter.sv - Three-wire bus master sharing one bus between TWM_NUM_REQ requesters.
// Round-robin arbitration by default; define TWM_FIXED_PRIORITY_EN for lowest-index-wins priority.
module tw_master_arbiter #(
   parameter int TWM_ADDRESS_BITS = 10,
   parameter int TWM_DATA_BITS    = 32,
   parameter int TWM_NUM_REQ      = 2,
   parameter int TWM_CLK_DIV      = 4,
   parameter int TWM_CS_GAP       = 2,
   localparam int ID_W = (TWM_NUM_REQ > 1) ? $clog2(TWM_NUM_REQ) : 1
) (
   input  logic                                    clock,
   input  logic                                    reset_n,
   input  logic [TWM_NUM_REQ-1:0]                  req,
   input  logic [TWM_NUM_REQ-1:0]                  req_wr,
   input  logic [TWM_NUM_REQ*TWM_ADDRESS_BITS-1:0] req_addr,
   input  logic [TWM_NUM_REQ*TWM_DATA_BITS-1:0]    req_wdata,
   output logic [TWM_NUM_REQ-1:0]                  grant,
   output logic                                    done,
   output logic [ID_W-1:0]                         done_id,
   output logic [TWM_DATA_BITS-1:0]                rd_data,
   output logic                                    busy,
   output logic                                    tw_bus_clock,
   output logic                                    tw_bus_chipselect,
   inout  wire                                     tw_bus_data
);
   localparam int N       = 1 + TWM_ADDRESS_BITS + TWM_DATA_BITS;
   localparam int BIT_W   = $clog2(N);
   localparam int DIV_W   = (TWM_CLK_DIV > 1) ? $clog2(TWM_CLK_DIV) : 1;
   localparam int GAP_CYC = TWM_CS_GAP * TWM_CLK_DIV;
   localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [2:0] {IDLE, LOW, HIGH, STOP, GAP} state_t;

   state_t                     state_q, state_d;
   logic [DIV_W-1:0]           div_q, div_d;
   logic [BIT_W-1:0]           bit_q, bit_d;
   logic [GAP_W-1:0]           gap_q, gap_d;
   logic [N-1:0]               sh_q, sh_d;
   logic                       is_wr_q, is_wr_d;
   logic [ID_W-1:0]            id_q, id_d;
   logic [ID_W-1:0]            done_id_q, done_id_d;
   logic [TWM_NUM_REQ-1:0]     grant_q, grant_d;
   logic [TWM_DATA_BITS-1:0]   rd_data_q, rd_data_d;
   logic                       done_q, done_d;
   logic                       busy_q, busy_d;
   logic                       sclk_q, sclk_d;
   logic                       cs_q, cs_d;
   logic                       oe_q, oe_d;
   logic [ID_W-1:0]            win;
   logic                       div_last;
`ifndef TWM_FIXED_PRIORITY_EN
   logic [ID_W-1:0]            ptr_q, ptr_d;

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= TWM_NUM_REQ) s = s - TWM_NUM_REQ;
      return ID_W'(s);
   endfunction
`endif

   // Later loop iterations override earlier ones, so the last hit is the highest-priority requester.
   always_comb begin
      win = '0;
`ifdef TWM_FIXED_PRIORITY_EN
      for (int k = TWM_NUM_REQ - 1; k >= 0; k--)
         if (req[k]) win = ID_W'(k);
`else
      for (int k = TWM_NUM_REQ - 1; k >= 0; k--)
         if (req[rr_idx(ptr_q, k)]) win = rr_idx(ptr_q, k);
`endif
   end

   assign div_last = (div_q == DIV_W'(TWM_CLK_DIV - 1));

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      sh_d      = sh_q;
      is_wr_d   = is_wr_q;
      id_d      = id_q;
      done_id_d = done_id_q;
      rd_data_d = rd_data_q;
      grant_d   = '0;
      done_d    = 1'b0;
      busy_d    = busy_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      oe_d      = oe_q;
`ifndef TWM_FIXED_PRIORITY_EN
      ptr_d     = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d[win] = 1'b1;
               sh_d    = {req_wr[win],
                          req_addr[int'(win) * TWM_ADDRESS_BITS +: TWM_ADDRESS_BITS],
                          req_wdata[int'(win) * TWM_DATA_BITS +: TWM_DATA_BITS]};
               is_wr_d = req_wr[win];
               id_d    = win;
               cs_d    = 1'b0;
               oe_d    = 1'b1;
               busy_d  = 1'b1;
               div_d   = '0;
               bit_d   = '0;
               state_d = LOW;
`ifndef TWM_FIXED_PRIORITY_EN
               ptr_d   = (win == ID_W'(TWM_NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
            end
         end
         LOW: begin
            div_d = div_q + 1'b1;
            if (div_last) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            div_d = div_q + 1'b1;
            if (div_last) begin
               div_d  = '0;
               sclk_d = 1'b0;
               // One shift both presents the next outgoing bit and captures the incoming one.
               sh_d   = {sh_q[N-2:0], tw_bus_data};
               if (!is_wr_q && bit_q == BIT_W'(TWM_ADDRESS_BITS)) oe_d = 1'b0;
               if (bit_q == BIT_W'(N - 1)) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  state_d = LOW;
               end
            end
         end
         STOP: begin
            div_d = div_q + 1'b1;
            if (div_last) begin
               div_d     = '0;
               cs_d      = 1'b1;
               oe_d      = 1'b0;
               done_d    = 1'b1;
               done_id_d = id_q;
               gap_d     = '0;
               if (!is_wr_q) rd_data_d = sh_q[TWM_DATA_BITS-1:0];
               // The IDLE cycle before the next grant counts towards the chipselect-high time.
               if (GAP_CYC > 1) begin
                  state_d = GAP;
               end else begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GAP_W'(GAP_CYC - 2)) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         sh_q      <= '0;
         is_wr_q   <= 1'b0;
         id_q      <= '0;
         done_id_q <= '0;
         rd_data_q <= '0;
         grant_q   <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         oe_q      <= 1'b0;
`ifndef TWM_FIXED_PRIORITY_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         sh_q      <= sh_d;
         is_wr_q   <= is_wr_d;
         id_q      <= id_d;
         done_id_q <= done_id_d;
         rd_data_q <= rd_data_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         oe_q      <= oe_d;
`ifndef TWM_FIXED_PRIORITY_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign grant             = grant_q;
   assign done              = done_q;
   assign done_id           = done_id_q;
   assign rd_data           = rd_data_q;
   assign busy              = busy_q;
   assign tw_bus_clock      = sclk_q;
   assign tw_bus_chipselect = cs_q;
   assign tw_bus_data       = oe_q ? sh_q[N-1] : 1'bz;
endmodule
